// File: rtl/coarse_pkg.sv
// Shared constants and helpers for the coarse left-shift path and its autorange controller.
// Pure declarations; no latency, no flow control.
// Any consumer of the coarse shift imports these so the widths stay in lockstep.
package coarse_pkg;
    localparam int DATA_W  = 14;
    localparam int MAG_W   = 13;
    localparam int ADJ_W   = 3;
    localparam int ADJ_MAX = 7;
    localparam int LZ_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DECIDE  = 2'd2
    } state_t;

    // Leading zeros of a 13-bit magnitude; zero input yields 13.
    function automatic logic [LZ_W-1:0] lzc(input logic [MAG_W-1:0] m);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = LZ_W'(MAG_W);
        found = 1'b0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            if (!found && m[i]) begin
                n     = LZ_W'(MAG_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Largest shift that keeps the sample inside full scale minus headroom.
    function automatic logic [ADJ_W-1:0] safe_shift(input logic [LZ_W-1:0] lz, input int headroom);
        int d;
        d = int'(lz) - headroom;
        if (d < 0)
            return '0;
        else if (d > ADJ_MAX)
            return ADJ_W'(ADJ_MAX);
        return ADJ_W'(d);
    endfunction
endpackage

// File: rtl/mag_lzc.sv
// Saturating absolute value of a signed sample plus its 13-bit leading-zero count.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result.
module mag_lzc
    import coarse_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [MAG_W-1:0]  mag,
    output logic [LZ_W-1:0]   lz
);
    logic [DATA_W-1:0] abs_val;

    always_comb begin
        abs_val = data[DATA_W-1] ? (~data + DATA_W'(1)) : data;
        // Only -8192 sets the top bit after negation; clip it to 8191.
        mag     = abs_val[DATA_W-1] ? '1 : abs_val[MAG_W-1:0];
        lz      = lzc(mag);
    end
endmodule

// File: rtl/coarse_autorange.sv
// Peak-tracking gain selector driving the coarse shift: fast attack, slow release, manual bypass.
// Fast attack 2 cycles after the offending sample; window decision 3 cycles after its last sample.
// No backpressure: every valid sample is accepted, including those arriving during DECIDE.
module coarse_autorange
    import coarse_pkg::*;
#(
    parameter int WINDOW_LOG2  = 14,
    parameter int HEADROOM     = 1,
    parameter int HOLD_WINDOWS = 4
)(
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    input  logic              en_i,
    input  logic [ADJ_W-1:0]  adj_manual_i,
    output logic [ADJ_W-1:0]  adj_o,
    output logic              update_o,
    output logic [MAG_W-1:0]  peak_o,
    output logic              peak_valid_o
);
    localparam int               CNT_W    = WINDOW_LOG2 + 1;
    localparam logic [CNT_W-1:0] WIN_LEN  = {1'b1, {WINDOW_LOG2{1'b0}}};
    localparam logic [3:0]       HOLD_TGT = 4'(HOLD_WINDOWS);

    logic [MAG_W-1:0] m_comb;
    logic [LZ_W-1:0]  lz_comb;

    logic             s1_vld;
    logic [MAG_W-1:0] s1_mag;
    logic [LZ_W-1:0]  s1_lz;

    state_t           state, state_nxt;
    logic [MAG_W-1:0] peak, peak_nxt, peak_o_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [3:0]       hold, hold_nxt, hold_inc;
    logic [ADJ_W-1:0] adj_nxt, adj_dec, tgt;
    logic             pv_nxt;

    mag_lzc u_mag_lzc (
        .data (data_i),
        .mag  (m_comb),
        .lz   (lz_comb)
    );

    // Stage 1 runs regardless of FSM state so no sample is lost around DECIDE.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_vld <= 1'b0;
            s1_mag <= '0;
            s1_lz  <= '0;
        end else begin
            s1_vld <= valid_i;
            s1_mag <= m_comb;
            s1_lz  <= lz_comb;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= ST_IDLE;
            adj_o        <= '0;
            update_o     <= 1'b0;
            peak_o       <= '0;
            peak_valid_o <= 1'b0;
            peak         <= '0;
            cnt          <= '0;
            hold         <= '0;
        end else begin
            state        <= state_nxt;
            adj_o        <= adj_nxt;
            update_o     <= (adj_nxt != adj_o);
            peak_o       <= peak_o_nxt;
            peak_valid_o <= pv_nxt;
            peak         <= peak_nxt;
            cnt          <= cnt_nxt;
            hold         <= hold_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        adj_nxt    = adj_o;
        adj_dec    = adj_o;
        peak_nxt   = peak;
        cnt_nxt    = cnt;
        hold_nxt   = hold;
        peak_o_nxt = peak_o;
        pv_nxt     = 1'b0;
        cnt_inc    = cnt + CNT_W'(1);
        hold_inc   = hold + 4'd1;
        tgt        = safe_shift(lzc(peak), HEADROOM);

        if (!en_i) begin
            state_nxt = ST_IDLE;
            adj_nxt   = adj_manual_i;
            peak_nxt  = '0;
            cnt_nxt   = '0;
            hold_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_MEASURE;

                ST_MEASURE: begin
                    if (s1_vld) begin
                        if (s1_lz < {1'b0, adj_o}) begin
                            adj_nxt  = safe_shift(s1_lz, HEADROOM);
                            peak_nxt = '0;
                            cnt_nxt  = '0;
                            hold_nxt = '0;
                        end else begin
                            peak_nxt = (s1_mag > peak) ? s1_mag : peak;
                            cnt_nxt  = cnt_inc;
                            if (cnt_inc == WIN_LEN)
                                state_nxt = ST_DECIDE;
                        end
                    end
                end

                ST_DECIDE: begin
                    peak_o_nxt = peak;
                    pv_nxt     = 1'b1;
                    state_nxt  = ST_MEASURE;
                    peak_nxt   = '0;
                    cnt_nxt    = '0;
                    if (tgt < adj_o) begin
                        adj_dec  = tgt;
                        hold_nxt = '0;
                    end else if (tgt > adj_o) begin
                        if (hold_inc == HOLD_TGT) begin
                            adj_dec  = adj_o + ADJ_W'(1);
                            hold_nxt = '0;
                        end else begin
                            hold_nxt = hold_inc;
                        end
                    end else begin
                        hold_nxt = '0;
                    end
                    adj_nxt = adj_dec;
                    // A sample landing in DECIDE opens the next window, judged against the new shift.
                    if (s1_vld) begin
                        if (s1_lz < {1'b0, adj_dec}) begin
                            adj_nxt  = safe_shift(s1_lz, HEADROOM);
                            hold_nxt = '0;
                        end else begin
                            peak_nxt = s1_mag;
                            cnt_nxt  = CNT_W'(1);
                        end
                    end
                end

                default: state_nxt = ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_coarse_autorange.sv
module tb_coarse_autorange;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [13:0] data = '0;
    logic        valid = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  adj_manual = '0;
    logic [2:0]  adj_o;
    logic        update_o;
    logic [12:0] peak_o;
    logic        peak_valid_o;

    int checks = 0;
    int errors = 0;

    coarse_autorange #(
        .WINDOW_LOG2  (4),
        .HEADROOM     (1),
        .HOLD_WINDOWS (2)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .data_i       (data),
        .valid_i      (valid),
        .en_i         (en),
        .adj_manual_i (adj_manual),
        .adj_o        (adj_o),
        .update_o     (update_o),
        .peak_o       (peak_o),
        .peak_valid_o (peak_valid_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_pv(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (peak_valid_o !== 1'b1 && n < 60);
        chk(tag, 32'(peak_valid_o), 32'd1);
    endtask

    initial begin
        int n;
        int pv_cnt;

        // Reset held while inputs toggle.
        for (int i = 0; i < 4; i++) begin
            data       = 14'(i * 1234 + 77);
            valid      = i[0];
            en         = ~i[0];
            adj_manual = 3'(i + 5);
            tick();
            chk("rst_adj", 32'(adj_o), 32'd0);
            chk("rst_upd", 32'(update_o), 32'd0);
            chk("rst_peak", 32'(peak_o), 32'd0);
            chk("rst_pv", 32'(peak_valid_o), 32'd0);
        end
        en = 1'b0; valid = 1'b0; data = '0; adj_manual = 3'd0;
        rstn = 1'b1;
        tick();
        chk("rel_adj", 32'(adj_o), 32'd0);
        chk("rel_upd", 32'(update_o), 32'd0);

        // Manual pass-through.
        adj_manual = 3'd5;
        tick();
        chk("man5_adj", 32'(adj_o), 32'd5);
        chk("man5_upd", 32'(update_o), 32'd1);
        tick();
        chk("man5_upd_once", 32'(update_o), 32'd0);
        adj_manual = 3'd3;
        tick();
        chk("man3_adj", 32'(adj_o), 32'd3);
        chk("man3_upd", 32'(update_o), 32'd1);
        tick();
        chk("man3_upd_once", 32'(update_o), 32'd0);
        adj_manual = 3'd0;
        tick();
        chk("man0_adj", 32'(adj_o), 32'd0);
        tick();

        // Slow release: constant 100 (t=5), one step every two windows.
        en = 1'b1; valid = 1'b1; data = 14'd100;
        for (int k = 1; k <= 12; k++) begin
            wait_pv("rel_pv", n);
            if (k >= 2) chk("rel_win_len", 32'(n), 32'd16);
            chk("rel_peak", 32'(peak_o), 32'd100);
            chk("rel_adj_step", 32'(adj_o), 32'((k / 2 > 5) ? 5 : k / 2));
            chk("rel_upd", 32'(update_o), 32'((k % 2 == 0 && k <= 10) ? 1 : 0));
        end

        // Fast attack: single 1000 (lz 3) from adj 5.
        data = 14'd1000;
        tick();
        data = 14'd100;
        chk("fa_adj_hold", 32'(adj_o), 32'd5);
        tick();
        chk("fa_adj", 32'(adj_o), 32'd2);
        chk("fa_upd", 32'(update_o), 32'd1);
        wait_pv("fa_pv", n);
        chk("fa_restart_len", 32'(n), 32'd17);
        chk("fa_peak", 32'(peak_o), 32'd100);
        chk("fa_adj_after", 32'(adj_o), 32'd2);
        chk("fa_upd_after", 32'(update_o), 32'd0);

        // Back to 5 manually, then constant 200 (lz 5, t 4): decided reduction.
        en = 1'b0; adj_manual = 3'd5;
        tick();
        chk("m5_adj", 32'(adj_o), 32'd5);
        chk("m5_pv", 32'(peak_valid_o), 32'd0);
        en = 1'b1; data = 14'd200;
        tick();
        chk("d200_no_fa", 32'(adj_o), 32'd5);
        wait_pv("d200_pv", n);
        chk("d200_peak", 32'(peak_o), 32'd200);
        chk("d200_adj", 32'(adj_o), 32'd4);
        chk("d200_upd", 32'(update_o), 32'd1);

        // Most negative sample saturates to 8191, drives shift to 0.
        data = 14'h2000;
        tick();
        chk("neg_adj_hold", 32'(adj_o), 32'd4);
        tick();
        chk("neg_adj", 32'(adj_o), 32'd0);
        chk("neg_upd", 32'(update_o), 32'd1);
        wait_pv("neg_pv", n);
        chk("neg_len", 32'(n), 32'd17);
        chk("neg_peak", 32'(peak_o), 32'd8191);
        chk("neg_adj_win", 32'(adj_o), 32'd0);

        // Drop enable mid-window: manual value next cycle, window discarded.
        data = 14'd100;
        for (int i = 0; i < 5; i++) tick();
        en = 1'b0; adj_manual = 3'd6;
        tick();
        chk("dis_adj", 32'(adj_o), 32'd6);
        chk("dis_upd", 32'(update_o), 32'd1);
        pv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (peak_valid_o === 1'b1) pv_cnt++;
        end
        chk("dis_no_pv", 32'(pv_cnt), 32'd0);
        chk("dis_peak_kept", 32'(peak_o), 32'd8191);

        // Asynchronous reset mid-window.
        en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rstn = 1'b0;
        #1;
        chk("arst_adj", 32'(adj_o), 32'd0);
        chk("arst_peak", 32'(peak_o), 32'd0);
        chk("arst_upd", 32'(update_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
